// File: rtl/final_memory_test_master.sv
// final_memory_test_master
//   Built-in self-test / initialisation master for a 32-bit x 4096-word
//   single-port on-chip memory. A FILL command writes an arithmetic pattern
//   (seed + k*step) over an address range. A CHECK command reads the range back
//   and compares it against the same pattern, counting mismatches and
//   latching the first failing address.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   cmd_*               : command handshake and arguments (sampled on accept)
//   done                : one-cycle completion pulse
//   err_count/err_flag  : CHECK mismatch status, held until the next accept
//   first_err_addr      : address of the first CHECK mismatch
//   avm_*               : Avalon-MM master port toward the memory slave
//
// Parameters
//   READ_LATENCY        : slave read latency in cycles (1 or 2)
module final_memory_test_master #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [11:0] cmd_base,
    input  logic [12:0] cmd_count,
    input  logic [31:0] cmd_seed,
    input  logic [31:0] cmd_step,
    output logic        done,
    output logic [12:0] err_count,
    output logic        err_flag,
    output logic [11:0] first_err_addr,
    output logic [11:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        avm_clken
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [12:0] MAX_WORDS = 13'd4096;
    localparam logic [12:0] DRAIN_CYC = 13'(READ_LATENCY);

    logic [2:0]  state_q, state_d;
    logic [11:0] addr_q, addr_d;      // address of the word currently on the bus
    logic [31:0] pat_q, pat_d;        // pattern of the word currently on the bus
    logic [31:0] step_q, step_d;
    logic [12:0] rem_q, rem_d;        // words left (FILL/READ) or drain cycles left
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [12:0] err_cnt_q, err_cnt_d;
    logic [11:0] first_q, first_d;

    // Expected data and address of each outstanding read, aligned so that
    // the last stage lines up with avm_readdata.
    logic [READ_LATENCY-1:0]        vld_q, vld_d;
    logic [READ_LATENCY-1:0][31:0]  exp_q, exp_d;
    logic [READ_LATENCY-1:0][11:0]  eaddr_q, eaddr_d;

    logic        accept;
    logic [12:0] cnt_clamp;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign cnt_clamp = (cmd_count > MAX_WORDS) ? MAX_WORDS : cmd_count;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        step_d    = step_q;
        rem_d     = rem_q;
        cs_d      = cs_q;
        wr_d      = wr_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = cmd_base;
                    pat_d     = cmd_seed;
                    step_d    = cmd_step;
                    rem_d     = cnt_clamp;
                    err_cnt_d = 13'd0;
                    first_d   = 12'd0;
                    if (cnt_clamp == 13'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = cmd_op ? S_READ : S_FILL;
                        cs_d    = 1'b1;
                        wr_d    = ~cmd_op;
                    end
                end
            end
            S_FILL, S_READ: begin
                if (rem_q == 13'd1) begin
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = (state_q == S_FILL) ? S_DONE : S_DRAIN;
                    rem_d   = DRAIN_CYC;
                end else begin
                    // 12-bit address wraps 0xFFF -> 0x000 on its own
                    addr_d = addr_q + 12'd1;
                    pat_d  = pat_q + step_q;
                    rem_d  = rem_q - 13'd1;
                end
            end
            S_DRAIN: begin
                if (rem_q == 13'd1) state_d = S_DONE;
                else                rem_d   = rem_q - 13'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        vld_d[0]   = cs_q & ~wr_q;
        exp_d[0]   = pat_q;
        eaddr_d[0] = addr_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            exp_d[i]   = exp_q[i-1];
            eaddr_d[i] = eaddr_q[i-1];
        end

        // The pipeline is empty whenever a command can be accepted, so this
        // never competes with the status clear above.
        if (vld_q[READ_LATENCY-1] && (avm_readdata != exp_q[READ_LATENCY-1])) begin
            err_cnt_d = err_cnt_q + 13'd1;
            if (err_cnt_q == 13'd0) first_d = eaddr_q[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pat_q     <= '0;
            step_q    <= '0;
            rem_q     <= '0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
            vld_q     <= '0;
            exp_q     <= '0;
            eaddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            step_q    <= step_d;
            rem_q     <= rem_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
            vld_q     <= vld_d;
            exp_q     <= exp_d;
            eaddr_q   <= eaddr_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err_count      = err_cnt_q;
    assign err_flag       = (err_cnt_q != 13'd0);
    assign first_err_addr = first_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = pat_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = wr_q;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;

endmodule

// File: doc/final_memory_test_master.md
# final_memory_test_master

Avalon-MM master that drives the 32-bit, 4096-word single-port on-chip memory slave from the opposite end of the interface. On command it either fills an address range with an arithmetic pattern, or reads the range back and checks it against the same pattern, reporting the error count and the first failing address. It sits beside the memory as a built-in self-test and initialisation engine, with command and status driven by the control logic.

## Interface
- READ_LATENCY, 1, slave read latency in cycles; 1 or 2 supported.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on the edge where cmd_valid & cmd_ready.
- cmd_op  in  1  operation select: 0 = FILL, 1 = CHECK.
- cmd_base  in  12  first word address.
- cmd_count  in  13  word count; 0 = no-op; values >4096 clamp to 4096.
- cmd_seed  in  32  pattern value for word 0.
- cmd_step  in  32  pattern increment.
- done  out  1  one-cycle pulse at command completion.
- err_count  out  13  CHECK mismatch count.
- err_flag  out  1  err_count != 0.
- first_err_addr  out  12  address of the first CHECK mismatch.
- avm_address  out  12  word address.
- avm_byteenable  out  4  constant 4'hF.
- avm_chipselect  out  1  bus access strobe.
- avm_write  out  1  write qualifier; chipselect & !write = read.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data, valid READ_LATENCY cycles after the read cycle.
- avm_clken  out  1  constant 1.

## Operation
- States: IDLE, FILL, READ, DRAIN, DONE.
  - IDLE -> FILL when a FILL command is accepted with count > 0.
  - IDLE -> READ when a CHECK command is accepted with count > 0.
  - IDLE -> DONE when a command is accepted with count == 0.
  - FILL -> DONE after N write cycles.
  - READ -> DRAIN after N read cycles.
  - DRAIN -> DONE after READ_LATENCY cycles.
  - DONE -> IDLE unconditionally.
- Word k (0 ≤ k < N):
  - address = (base + k) mod 4096; wraps 0xFFF -> 0x000.
  - pattern = (seed + k·step) mod 2^32, generated by an accumulator; no multiplier.
- FILL: chipselect = write = 1 each cycle, with writedata = pattern(k).
- CHECK:
  - chipselect = 1, write = 0, one read per cycle, no gaps.
  - Expected value and address travel through a READ_LATENCY-deep shift register aligned with avm_readdata.
  - Each mismatch increments err_count.
  - The first mismatch latches first_err_addr.
- On accept: err_count, err_flag and first_err_addr clear to 0.
- After DONE: status holds until the next accept.
- Commands presented while busy are not accepted (cmd_ready = 0); inputs are sampled only at accept.
- The same address appearing twice (N = 4096 plus wrap never exceeds one pass) needs no special handling.

## Timing
- Reset values:
  - cmd_ready = 1.
  - done = 0.
  - err_count = 0, err_flag = 0, first_err_addr = 0.
  - avm_chipselect = 0, avm_write = 0.
  - avm_address = 0, avm_writedata = 0.
  - avm_byteenable = 4'hF, avm_clken = 1.
- Cycle 0 is the accept edge. The bus is active in cycles 1..N with registered outputs; bus strobes are low in every other cycle.
- FILL: done = 1 in cycle N+1; cmd_ready = 1 in cycle N+2.
- CHECK:
  - The read issued in cycle j is compared in cycle j+READ_LATENCY.
  - done = 1 in cycle N+READ_LATENCY+1, with final status already valid in that cycle.
- count == 0: done = 1 in cycle 1, no bus access.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). No done pulse is emitted. The in-flight command is discarded.
- Throughput: one word per cycle. Back-to-back command accept is possible the cycle after DONE.

## Test plan
- FILL base 0x000, count 4, seed 0x100, step 1 -> writes addr 0..3 with data 0x100..0x103 in cycles 1..4; done in cycle 5.
- CHECK the same range against a READ_LATENCY=1 behavioural memory -> reads in cycles 1..4; done in cycle 6; err_count 0, err_flag 0.
- Overwrite addr 0x002 with 0, then CHECK base 0, count 4 -> err_count 1, err_flag 1, first_err_addr 0x002. Repeat with READ_LATENCY=2 -> same result, done in cycle 7.
- FILL base 0xFFE, count 4, seed 0xFFFFFFFF, step 2 -> addresses FFE, FFF, 000, 001 with data FFFFFFFF, 00000001, 00000003, 00000005.
- count 0 -> done in cycle 1, chipselect never high. count 5000 -> exactly 4096 writes, done in cycle 4097.
- Assert reset in cycle 3 of a count-8 FILL -> chipselect low immediately, cmd_ready 1 after release, no done pulse. A following FILL completes normally.
